// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor controller.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Counter must be able to hold the value WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Request/result bundle for serial_sub_ctrl; zero flag present only with SERIAL_SUB_ZERO_FLAG_EN.
interface serial_sub_ctrl_if
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    logic             zero;

    modport master (output start, a, b, input busy, done, diff, borrow, zero);
    modport slave  (input start, a, b, output busy, done, diff, borrow, zero);
`else
    modport master (output start, a, b, input busy, done, diff, borrow);
    modport slave  (input start, a, b, output busy, done, diff, borrow);
`endif
endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor: a - b - bin.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);
    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: diff = a - b mod 2^WIDTH, one bit per clock, LSB first.
// Optional zero-result flag enabled by SERIAL_SUB_ZERO_FLAG_EN.
//
// state | meaning
// IDLE  | waiting for start; operands captured on accept
// SHIFT | one full-subtractor step per clock, WIDTH steps
// DONE  | result valid, done pulses for this one cycle
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_sub_ctrl_if.slave  bus
);
    localparam int CW = cnt_width(WIDTH);

    state_t           state, next_state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q, b_q, diff_q;
    logic             br_q, busy_q, done_q;
    logic             d_bit, br_next, last_step;
    logic [WIDTH-1:0] diff_shift;

    full_subtractor u_fs (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .diff (d_bit),
        .bout (br_next)
    );

    assign last_step  = (cnt == CW'(WIDTH - 1));
    assign diff_shift = {d_bit, diff_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = SHIFT;
            SHIFT:   if (last_step) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            diff_q <= '0;
            br_q   <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (next_state == SHIFT);
            done_q <= (next_state == DONE);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q    <= bus.a;
                        b_q    <= bus.b;
                        diff_q <= '0;
                        br_q   <= 1'b0;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    a_q    <= a_q >> 1;
                    b_q    <= b_q >> 1;
                    br_q   <= br_next;
                    diff_q <= diff_shift;
                    cnt    <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_SUB_ZERO_FLAG_EN
    logic zero_q;

    // Evaluated on the final step so the flag is valid alongside done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            zero_q <= 1'b0;
        end else if (state == SHIFT && last_step) begin
            zero_q <= (diff_shift == '0);
        end
    end

    assign bus.zero = zero_q;
`endif

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.diff   = diff_q;
    assign bus.borrow = br_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl (WIDTH=8): directed operands, monitor checks each done.
module tb_serial_sub_ctrl;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         borrow;
        logic         zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   done_count = 0;
    exp_t sb[$];

    serial_sub_ctrl_if #(.WIDTH(W)) bus ();

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, " busy"},   32'(bus.busy),   32'd0);
        chk({tag, " done"},   32'(bus.done),   32'd0);
        chk({tag, " diff"},   32'(bus.diff),   32'd0);
        chk({tag, " borrow"}, 32'(bus.borrow), 32'd0);
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        chk({tag, " zero"},   32'(bus.zero),   32'd0);
`endif
    endtask

    // Monitor: every done pulse consumes one expected result.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.done) begin
            done_count++;
            if (sb.size() == 0) begin
                chk("unexpected done", 32'(bus.done), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("diff",   32'(bus.diff),   32'(e.diff));
                chk("borrow", 32'(bus.borrow), 32'(e.borrow));
`ifdef SERIAL_SUB_ZERO_FLAG_EN
                chk("zero",   32'(bus.zero),   32'(e.zero));
`endif
            end
        end
    end

    // Called at a negedge with the DUT in IDLE. glitch_at / rst_at select a SHIFT cycle (0 = none).
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] ed, input logic eb, input logic ez,
                      input int glitch_at, input int rst_at);
        int busy_n;
        int done_at;
        int dc0;
        exp_t e;
        dc0     = done_count;
        busy_n  = 0;
        done_at = 0;
        e.diff = ed; e.borrow = eb; e.zero = ez;
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        if (rst_at == 0) sb.push_back(e);
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int k = 1; k <= 20 && done_at == 0; k++) begin
            @(negedge clk);
            if (k == glitch_at) begin
                bus.start = 1'b1;
                bus.a     = ~a;
                bus.b     = ~b;
            end else if (glitch_at != 0 && k == glitch_at + 1) begin
                bus.start = 1'b0;
            end
            if (k == rst_at) begin
                rst_n = 1'b0;
                #1 chk_outputs_zero("abort");
                @(negedge clk);
                rst_n = 1'b1;
                repeat (12) @(negedge clk);
                chk("no done after abort", 32'(done_count - dc0), 32'd0);
                return;
            end
            if (bus.busy) busy_n++;
            if (bus.done) done_at = k;
        end
        if (done_at == 0) begin
            chk("done timeout", 32'd0, 32'd1);
            if (sb.size() != 0) void'(sb.pop_front());
            return;
        end
        chk("done latency", 32'(done_at), 32'(W + 1));
        chk("busy cycles",  32'(busy_n),  32'(W));
        @(negedge clk);
        chk("done single pulse", 32'(bus.done), 32'd0);
        chk("idle busy",         32'(bus.busy), 32'd0);
        chk("diff hold",         32'(bus.diff), 32'(ed));
        chk("borrow hold",       32'(bus.borrow), 32'(eb));
        chk("done count",        32'(done_count - dc0), 32'd1);
    endtask

    initial begin
        int seen;
        int idx[3];
        exp_t e;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");

        // Release and request on the same cycle: first edge must accept.
        rst_n = 1'b1;
        op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 0, 0);
        op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 0, 0);
        op(8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0, 0, 0);
        op(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 0, 0);
        op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 0, 0);
        op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 0, 0);
        op(8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0, 3, 0);
        op(8'h77, 8'h22, 8'h55, 1'b0, 1'b0, 0, 4);
        op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 0, 0);

        // Start held high: back-to-back operations, one done every W+2 cycles.
        e.diff = 8'h05; e.borrow = 1'b0; e.zero = 1'b0;
        repeat (3) sb.push_back(e);
        seen = 0;
        bus.start = 1'b1;
        bus.a     = 8'h09;
        bus.b     = 8'h04;
        for (int k = 1; k <= 40 && seen < 3; k++) begin
            @(negedge clk);
            if (bus.done) begin
                idx[seen] = k;
                seen++;
                if (seen == 3) bus.start = 1'b0;
            end
        end
        chk("held dones seen", 32'(seen), 32'd3);
        if (seen == 3) begin
            chk("held first done",  32'(idx[0]), 32'(W + 1));
            chk("held period 1",    32'(idx[1] - idx[0]), 32'(W + 2));
            chk("held period 2",    32'(idx[2] - idx[1]), 32'(W + 2));
        end
        repeat (2) @(negedge clk);
        chk("held stop busy", 32'(bus.busy), 32'd0);
        chk("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_sub_ctrl.md
SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous and active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a  input  WIDTH  minuend; captured on the accepted start.
REQ-006 b  input  WIDTH  subtrahend; captured on the accepted start.
REQ-007 busy  output  1  high while in SHIFT.
REQ-008 done  output  1  single-cycle pulse; result valid.
REQ-009 diff  output  WIDTH  a minus b, modulo 2^WIDTH.
REQ-010 borrow  output  1  final borrow; high when a < b unsigned.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-012 In IDLE with start=1 at an edge, the block SHALL capture a and b, clear the borrow register and the bit counter to 0, and enter SHIFT.
REQ-013 In SHIFT, each edge SHALL process one bit, LSB first, through one full-subtractor step:
- d = a_i ^ b_i ^ br
- br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)
REQ-014 Each SHIFT step SHALL shift d into diff from the MSB side and increment the counter.
REQ-015 After exactly WIDTH SHIFT steps, the FSM SHALL enter DONE; it SHALL return to IDLE on the next edge.
REQ-016 done SHALL be high for exactly the one cycle in DONE, i.e. WIDTH cycles after the edge that sampled start.
REQ-017 diff and borrow SHALL hold their values from DONE until the next accepted start.
REQ-018 start in SHIFT or DONE SHALL be ignored with no effect on state, operands or outputs; start held high in IDLE SHALL begin a new operation.
REQ-019 Changes on a and b after capture SHALL NOT affect the operation in flight.
REQ-020 Outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-021 Asserting rst_n low SHALL immediately force:
- IDLE state;
- busy=0, done=0, diff=0, borrow=0;
- counter and operand registers to 0.
REQ-022 Reset asserted mid-SHIFT SHALL abort the operation; no done pulse SHALL follow release.
REQ-023 After rst_n release, the first rising edge SHALL be able to accept start.

Configuration
REQ-024 With macro SERIAL_SUB_ZERO_FLAG_EN defined, the block SHALL have an extra output zero (1 bit):
- registered, updated in DONE, high when diff==0;
- reset to 0; holds until the next accepted start.
REQ-025 Without SERIAL_SUB_ZERO_FLAG_EN, the zero port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-026 Package serial_sub_pkg SHALL hold:
- the FSM state enum (IDLE, SHIFT, DONE);
- the default WIDTH constant;
- the counter-width function (clog2 of WIDTH+1).
REQ-027 The bit step SHALL be a sub-module full_subtractor (inputs a, b, bin; outputs diff, bout), purely combinational, instantiated once.

Verification
REQ-028 WIDTH=8: start with a=0x05, b=0x03 -> done 8 cycles later, diff=0x02, borrow=0, busy high exactly 8 cycles.
REQ-029 a=0x03, b=0x05 -> diff=0xFE, borrow=1; a=0xFF, b=0x00 -> diff=0xFF, borrow=0.
REQ-030 a=0x00, b=0x00 -> diff=0x00, borrow=0, zero=1 (macro defined); a=0x80, b=0x01 -> zero=0.
REQ-031 start pulsed and a/b changed on the 3rd SHIFT cycle -> result unchanged, exactly one done pulse.
REQ-032 rst_n low on the 4th SHIFT cycle -> outputs 0 immediately, no done after release; next start 0x10-0x01 -> diff=0x0F.
REQ-033 start held high continuously -> operations repeat, with one done every WIDTH+2 cycles.
